// File: rtl/psg_register_controller_if.sv
// Host-side bus of the PSG register file: mode strobes, data/address in, read-back out.
// Mode is {bdir,bc1}, sampled every clk edge: 00 inactive, 01 read, 10 write, 11 latch address.
interface psg_register_controller_if;
  logic       bdir;
  logic       bc1;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;

  modport master (output bdir, bc1, data_in, input data_out, data_oe);
  modport slave  (input bdir, bc1, data_in, output data_out, data_oe);
endinterface

// File: rtl/psg_register_controller.sv
// Sixteen-entry PSG register file behind a latch/write/read strobe bus, with
// width-masked storage, registered read-back and an envelope-restart pulse on R13 writes.
module psg_register_controller #(
  parameter logic [3:0] CHIP_ADDR = 4'h0
) (
  input  logic                            clk,
  input  logic                            reset,
  psg_register_controller_if.slave        bus,
  output logic [11:0]                     tone_period_a,
  output logic [11:0]                     tone_period_b,
  output logic [11:0]                     tone_period_c,
  output logic [4:0]                      noise_period,
  output logic [7:0]                      mixer,
  output logic [4:0]                      amp_a,
  output logic [4:0]                      amp_b,
  output logic [4:0]                      amp_c,
  output logic [15:0]                     env_period,
  output logic                            env_continue,
  output logic                            env_attack,
  output logic                            env_alternate,
  output logic                            env_hold,
  output logic                            env_restart,
  output logic [7:0]                      io_a,
  output logic [7:0]                      io_b,
  output logic [1:0]                      state_dbg
);

  // Encoding equals the bus mode so the next state is simply the sampled mode.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_WRITE = 2'b10,
    S_LATCH = 2'b11
  } state_t;

  state_t      state;
  logic [1:0]  mode;
  logic [3:0]  addr;
  logic        addr_valid;
  logic [7:0]  regs [16];

  assign mode = {bus.bdir, bus.bc1};

  function automatic logic [7:0] reg_mask(input logic [3:0] a);
    case (a)
      4'd1, 4'd3, 4'd5, 4'd13: reg_mask = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10: reg_mask = 8'h1F;
      default:                 reg_mask = 8'hFF;
    endcase
  endfunction

  // Reset clears addr_valid, so a WRITE still held after reset cannot commit
  // until the host leaves WRITE and latches an address again.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
      addr         <= 4'h0;
      addr_valid   <= 1'b0;
      state        <= S_IDLE;
      env_restart  <= 1'b0;
      bus.data_oe  <= 1'b0;
      bus.data_out <= 8'h00;
    end else begin
      state        <= state_t'(mode);
      env_restart  <= 1'b0;
      bus.data_oe  <= 1'b0;
      bus.data_out <= 8'h00;
      case (state_t'(mode))
        S_LATCH: begin
          addr       <= bus.data_in[3:0];
          addr_valid <= (bus.data_in[7:4] == CHIP_ADDR);
        end
        S_WRITE: begin
          if (state != S_WRITE && addr_valid) begin
            regs[addr]  <= bus.data_in & reg_mask(addr);
            env_restart <= (addr == 4'd13);
          end
        end
        S_READ: begin
          if (addr_valid) begin
            bus.data_oe  <= 1'b1;
            bus.data_out <= regs[addr];
          end
        end
        default: ;
      endcase
    end
  end

  assign tone_period_a = {regs[1][3:0], regs[0]};
  assign tone_period_b = {regs[3][3:0], regs[2]};
  assign tone_period_c = {regs[5][3:0], regs[4]};
  assign noise_period  = regs[6][4:0];
  assign mixer         = regs[7];
  assign amp_a         = regs[8][4:0];
  assign amp_b         = regs[9][4:0];
  assign amp_c         = regs[10][4:0];
  assign env_period    = {regs[12], regs[11]};
  assign env_continue  = regs[13][3];
  assign env_attack    = regs[13][2];
  assign env_alternate = regs[13][1];
  assign env_hold      = regs[13][0];
  assign io_a          = regs[14];
  assign io_b          = regs[15];
  assign state_dbg     = state;

endmodule

// File: doc/psg_register_controller.md
PSG_REGISTER_CONTROLLER -- requirements
Module: psg_register_controller

Interface
REQ-001 The block SHALL have parameter CHIP_ADDR, default 4'h0, the upper address nibble that selects this chip during address latch.
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port bdir, input, 1, bus direction strobe.
REQ-005 The block SHALL have port bc1, input, 1, bus control strobe.
REQ-006 The block SHALL have port data_in, input, 8, bus data and address.
REQ-007 The block SHALL have port data_out, output, 8, read-back data.
REQ-008 The block SHALL have port data_oe, output, 1, read-back drive enable.
REQ-009 The block SHALL have ports tone_period_a, tone_period_b and tone_period_c, each output, 12, {R1[3:0],R0}, {R3[3:0],R2} and {R5[3:0],R4}.
REQ-010 The block SHALL have port noise_period, output, 5, R6[4:0].
REQ-011 The block SHALL have port mixer, output, 8, R7.
REQ-012 The block SHALL have ports amp_a, amp_b and amp_c, each output, 5, R8[4:0], R9[4:0] and R10[4:0].
REQ-013 The block SHALL have port env_period, output, 16, {R12,R11}.
REQ-014 The block SHALL have ports env_continue, env_attack, env_alternate and env_hold, each output, 1, R13[3], R13[2], R13[1] and R13[0].
REQ-015 The block SHALL have port env_restart, output, 1, one-cycle pulse that resets the envelope generator.
REQ-016 The block SHALL have ports io_a and io_b, each output, 8, R14 and R15.

Function
REQ-017 Bus mode SHALL be {bdir,bc1}: 00 INACTIVE, 01 READ, 10 WRITE, 11 LATCH; it SHALL be sampled every clk edge.
REQ-018 In LATCH, addr SHALL be loaded from data_in[3:0] on every edge (last value wins), and addr_valid SHALL be set to (data_in[7:4]==CHIP_ADDR).
REQ-019 The FSM SHALL have states IDLE, LATCH, WRITE and READ, with next state always equal to the sampled mode; there SHALL be no illegal states.
REQ-020 A write SHALL commit exactly once per WRITE episode, on the first edge where mode==10 and the previous state!=WRITE, using data_in sampled on that edge; further cycles of the same episode SHALL be ignored.
REQ-021 A commit SHALL occur only when addr_valid=1; otherwise the bus cycle SHALL be ignored.
REQ-022 Stored widths SHALL be masked: R1, R3, R5 and R13 keep 4 bits; R6 and R8-R10 keep 5 bits; all others keep 8; discarded bits SHALL read as 0.
REQ-023 The output ports SHALL reflect a committed value in the cycle immediately after the commit edge (1-cycle latency).
REQ-024 Every valid commit to R13 SHALL assert env_restart for exactly the one cycle after the commit edge, even when the value is unchanged; commits to other registers SHALL NOT pulse it.
REQ-025 Back-to-back R13 write episodes separated by at least one non-WRITE cycle SHALL each produce their own pulse.
REQ-026 In READ with addr_valid=1, data_out SHALL be registered as the masked value of R[addr] and data_oe SHALL be 1, both valid from the cycle after the first READ edge and held while in READ.
REQ-027 data_oe SHALL be 0 in the cycle after any edge where mode!=READ or addr_valid=0, and data_out SHALL then be 8'h00.
REQ-028 A READ that follows a commit to the same register SHALL return the new value.
REQ-029 Changing from LATCH directly to WRITE or READ with no INACTIVE cycle between them SHALL be legal and SHALL use the last latched address.

Reset
REQ-030 When reset is sampled high, R0-R15 SHALL be set to 0, addr to 0, addr_valid to 0, state to IDLE, and env_restart, data_oe and data_out to 0; reset SHALL override any bus activity in the same cycle.
REQ-031 An assertion of reset during a WRITE or READ episode SHALL abort that episode; if the mode is still WRITE after reset is released, it SHALL NOT commit until the mode leaves WRITE and re-enters it.

Verification
REQ-032 The bench SHALL drive LATCH 8'h0D, then WRITE 8'hFE held 3 cycles -> R13=4'hE, {continue,attack,alternate,hold}=1110, env_restart high for exactly 1 cycle.
REQ-033 The bench SHALL drive LATCH 8'h0B, WRITE 8'h34, LATCH 8'h0C, WRITE 8'h12 -> env_period=16'h1234, with env_restart never asserted.
REQ-034 The bench SHALL drive LATCH 8'h1D (wrong chip) then WRITE 8'h09 -> all registers unchanged, env_restart 0, and a following READ gives data_oe=0.
REQ-035 The bench SHALL drive LATCH 8'h01, WRITE 8'hFF, then READ -> data_out=8'h0F with data_oe=1 one cycle after READ starts, and tone_period_a[11:8]=4'hF.
REQ-036 The bench SHALL do two R13 write episodes of 8'h09 separated by one INACTIVE cycle -> two distinct one-cycle env_restart pulses.
REQ-037 The bench SHALL assert reset during a WRITE to R8 and hold the mode at WRITE after release -> R8=0 and no commit until the mode leaves WRITE and re-enters it.
